host_cmd_deframer: RTL

- Synthesizable parser for the host command stream arriving on the host_in FIFO.
- Each frame is: destination, command, length_hi, length_lo, N payload words, checksum_hi, checksum_lo.
- Routes payload words to one slot or to all slots (broadcast), checks the 32-bit checksum, and reports a per-frame status and error counters.
- Sits between host_in and the per-slot command/audio FIFOs in da_platform. It replaces ad-hoc framing logic and is generalised in word width, slot count and maximum length.

---
 rtl/host_cmd_deframer_pkg.sv | 29 ++
 rtl/host_frame_checksum.sv | 32 +++
 rtl/host_cmd_deframer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/host_cmd_deframer_pkg.sv
// Shared types for the host command deframer: parser states, status codes
// and the broadcast destination value.
package host_cmd_deframer_pkg;

  typedef enum logic [3:0] {
    ST_DEST,
    ST_CMD,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_DONE,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK   = 2'd0,
    STATUS_CSUM = 2'd1,
    STATUS_DEST = 2'd2,
    STATUS_LEN  = 2'd3
  } status_t;

  localparam logic [7:0] BROADCAST_DEST = 8'hFF;
  localparam int LEN_W = 24;
  // Drain has to count length+2 words, hence one bit wider than the length.
  localparam int CNT_W = 25;

endpackage

// File: rtl/host_frame_checksum.sv
// 32-bit running sum of zero-extended payload words, compared against the
// checksum received at the end of the frame.
module host_frame_checksum #(
  parameter int host_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accumulate,
  input  logic [host_width-1:0] word,
  input  logic [31:0]           expected,
  output logic                  match
);

  logic [31:0] acc;
  logic [31:0] word_ext;

  assign word_ext = 32'(word);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accumulate) begin
      acc <= acc + word_ext;
    end
  end

  assign match = (acc == expected);

endmodule

// File: rtl/host_cmd_deframer.sv
// Host command stream parser: routes payload words to one or all slots,
// verifies the frame checksum and keeps per-frame status counters.
module host_cmd_deframer
  import host_cmd_deframer_pkg::*;
#(
  parameter int         host_width     = 16,
  parameter int         num_slots      = 4,
  parameter int         max_length     = 1024,
  parameter logic [7:0] broadcast_dest = BROADCAST_DEST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [host_width-1:0] in_data,
  input  logic                  in_enable,
  output logic                  in_ready,
  output logic [host_width-1:0] out_data,
  output logic                  out_enable,
  input  logic                  out_ready,
  output logic [num_slots-1:0]  out_slot_mask,
  output logic [7:0]            out_command,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  status_valid,
  output logic [1:0]            status_code,
  output logic [15:0]           frames_ok,
  output logic [15:0]           frames_err
);

  state_t           state, state_nxt;
  status_t          code;
  logic             over;
  logic             forwarding;
  logic             accept;
  logic             csum_match;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] len_full;
  logic             len_too_big;
  logic [CNT_W-1:0] remaining;
  logic [15:0]      csum_hi, csum_lo;

  function automatic logic [num_slots-1:0] decode_dest(input logic [7:0] dest);
    if (dest == broadcast_dest) return '1;
    if (int'(dest) < num_slots) return num_slots'(1) << dest;
    return '0;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A zero mask marks a bad destination: its payload is consumed but never forwarded.
  assign forwarding  = (out_slot_mask != '0);
  assign accept      = in_enable && in_ready;
  assign len_full    = {length[23:16], in_data[15:0]};
  assign len_too_big = (32'(len_full) > 32'(max_length));
  assign out_data    = in_data;
  assign status_code = code;

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    out_enable   = 1'b0;
    out_first    = 1'b0;
    out_last     = 1'b0;
    status_valid = 1'b0;
    code         = STATUS_OK;
    case (state)
      ST_DEST:    begin in_ready = 1'b1; if (in_enable) state_nxt = ST_CMD; end
      ST_CMD:     begin in_ready = 1'b1; if (in_enable) state_nxt = ST_LEN_HI; end
      ST_LEN_HI:  begin in_ready = 1'b1; if (in_enable) state_nxt = ST_LEN_LO; end
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (in_enable) begin
          if (len_too_big)             state_nxt = ST_DRAIN;
          else if (len_full == '0)     state_nxt = ST_CSUM_HI;
          else                         state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready   = forwarding ? out_ready : 1'b1;
        out_enable = forwarding && in_enable;
        out_first  = (remaining == {1'b0, length});
        out_last   = (remaining == CNT_W'(1));
        if (in_enable && in_ready && remaining == CNT_W'(1)) state_nxt = ST_CSUM_HI;
      end
      ST_CSUM_HI: begin in_ready = 1'b1; if (in_enable) state_nxt = ST_CSUM_LO; end
      ST_CSUM_LO: begin in_ready = 1'b1; if (in_enable) state_nxt = ST_DONE; end
      ST_DONE: begin
        status_valid = 1'b1;
        if (over)             code = STATUS_LEN;
        else if (!forwarding) code = STATUS_DEST;
        else if (!csum_match) code = STATUS_CSUM;
        else                  code = STATUS_OK;
        state_nxt = ST_DEST;
      end
      ST_DRAIN: begin
        in_ready = 1'b1;
        if (in_enable && remaining == CNT_W'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_DEST;
    endcase
    if (reset) in_ready = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_DEST;
      out_slot_mask <= '0;
      out_command   <= '0;
      over          <= 1'b0;
      length        <= '0;
      remaining     <= '0;
      csum_hi       <= '0;
      csum_lo       <= '0;
      frames_ok     <= '0;
      frames_err    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        case (state)
          ST_DEST: begin
            out_slot_mask <= decode_dest(in_data[7:0]);
            over          <= 1'b0;
          end
          ST_CMD:    out_command    <= in_data[7:0];
          ST_LEN_HI: length[23:16]  <= in_data[7:0];
          ST_LEN_LO: begin
            length[15:0] <= in_data[15:0];
            over         <= len_too_big;
            remaining    <= len_too_big ? {1'b0, len_full} + CNT_W'(2) : {1'b0, len_full};
          end
          ST_DATA, ST_DRAIN: remaining <= remaining - CNT_W'(1);
          ST_CSUM_HI: csum_hi <= in_data[15:0];
          ST_CSUM_LO: csum_lo <= in_data[15:0];
          default: ;
        endcase
      end
      if (state == ST_DONE) begin
        if (code == STATUS_OK) frames_ok  <= sat_inc(frames_ok);
        else                   frames_err <= sat_inc(frames_err);
      end
    end
  end

  host_frame_checksum #(.host_width(host_width)) u_checksum (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept && state == ST_LEN_LO),
    .accumulate (accept && state == ST_DATA),
    .word       (in_data),
    .expected   ({csum_hi, csum_lo}),
    .match      (csum_match)
  );

endmodule
